// File: rtl/uc_sequencer.sv
// Control-unit sequencer: fetches A/B/opcode, runs one ALU op, writes the result back to register A.
// Optional `UC_MUL_EN` adds opcode 8 (single-cycle multiply); the default build leaves it out.
module uc_sequencer #(
  parameter int WIDTH   = 8,
  parameter int WB_HOLD = 1
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             start,
  input  logic [WIDTH-1:0] regA,
  input  logic [WIDTH-1:0] regB,
  input  logic [7:0]       opcode,
  output logic [WIDTH-1:0] tempRegA,
  output logic             flagUC,
  output logic [WIDTH-1:0] bufferOut,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             carry,
  output logic             zero
);

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, WB, DONE} state_t;

  localparam int CW = (WB_HOLD > 1) ? $clog2(WB_HOLD) : 1;
  localparam logic [CW-1:0] LAST = CW'(WB_HOLD - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [7:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             error_q, error_d;
  logic             flag_uc_q, flag_uc_d;

  logic [WIDTH:0]   alu_res;
  logic             alu_legal;
`ifdef UC_MUL_EN
  logic [2*WIDTH-1:0] prod;
`endif

  // Bit WIDTH of alu_res is the carry/borrow/shift-out for the op
  always_comb begin
    alu_res   = '0;
    alu_legal = 1'b1;
`ifdef UC_MUL_EN
    prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
`endif
    case (op_q)
      8'd0: alu_res = {1'b0, a_q} + {1'b0, b_q};
      8'd1: alu_res = {1'b0, a_q} - {1'b0, b_q};
      8'd2: alu_res = {1'b0, a_q & b_q};
      8'd3: alu_res = {1'b0, a_q | b_q};
      8'd4: alu_res = {1'b0, a_q ^ b_q};
      8'd5: alu_res = {1'b0, ~a_q};
      8'd6: alu_res = {a_q, 1'b0};
      8'd7: alu_res = {a_q[0], 1'b0, a_q[WIDTH-1:1]};
`ifdef UC_MUL_EN
      8'd8: alu_res = {|prod[2*WIDTH-1:WIDTH], prod[WIDTH-1:0]};
`endif
      default: alu_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    error_d  = error_q;
    case (state_q)
      IDLE: if (start) state_d = FETCH;
      FETCH: begin
        a_d     = regA;
        b_d     = regB;
        op_d    = opcode;
        state_d = EXEC;
      end
      EXEC: begin
        cnt_d = '0;
        if (alu_legal) begin
          result_d = alu_res[WIDTH-1:0];
          carry_d  = alu_res[WIDTH];
          zero_d   = (alu_res[WIDTH-1:0] == '0);
          error_d  = 1'b0;
          state_d  = WB;
        end else begin
          error_d  = 1'b1;
          state_d  = DONE;
        end
      end
      WB: begin
        if (cnt_q == LAST) state_d = DONE;
        else               cnt_d   = cnt_q + ONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Registered so the register file's async set path sees a clean flop output
    flag_uc_d = (state_d == WB);
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      error_q   <= 1'b0;
      flag_uc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      error_q   <= error_d;
      flag_uc_q <= flag_uc_d;
    end
  end

  assign tempRegA  = result_q;
  assign bufferOut = result_q;
  assign flagUC    = flag_uc_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign error     = error_q;
  assign carry     = carry_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_uc_sequencer.sv
// Randomized self-checking bench for uc_sequencer against an arithmetic reference model.
// Honours `UC_MUL_EN` so opcode 8 is expected legal or illegal to match the build.
module tb_uc_sequencer;

  localparam int W = 8;
  localparam int H = 4;

  logic         clock = 1'b0;
  logic         resetN = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] regA = '0, regB = '0;
  logic [7:0]   opcode = '0;
  logic [W-1:0] tempRegA, bufferOut;
  logic         flagUC, busy, done, error, carry, zero;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] expTemp = '0;
  logic         expCarry = 1'b0, expZero = 1'b0, expError = 1'b0;

  uc_sequencer #(.WIDTH(W), .WB_HOLD(H)) dut (
    .clock(clock), .resetN(resetN), .start(start), .regA(regA), .regB(regB),
    .opcode(opcode), .tempRegA(tempRegA), .flagUC(flagUC), .bufferOut(bufferOut),
    .busy(busy), .done(done), .error(error), .carry(carry), .zero(zero)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag, input bit eFlag, input bit eDone, input bit eBusy);
    checkOutput({tag, ".flagUC"}, 32'(flagUC), 32'(eFlag));
    checkOutput({tag, ".done"}, 32'(done), 32'(eDone));
    checkOutput({tag, ".busy"}, 32'(busy), 32'(eBusy));
    checkOutput({tag, ".tempRegA"}, 32'(tempRegA), 32'(expTemp));
    checkOutput({tag, ".bufferOut"}, 32'(bufferOut), 32'(expTemp));
    checkOutput({tag, ".carry"}, 32'(carry), 32'(expCarry));
    checkOutput({tag, ".zero"}, 32'(zero), 32'(expZero));
    checkOutput({tag, ".error"}, 32'(error), 32'(expError));
  endtask

  function automatic void refModel(input int a, input int b, input int op,
                                   output bit ok, output int res, output bit cy);
    int full;
    ok = 1'b1; res = 0; cy = 1'b0; full = 0;
    case (op)
      0: begin full = a + b; res = full % 256; cy = (full > 255); end
      1: begin res = (a - b + 256) % 256; cy = (a < b); end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = 255 - a;
      6: begin res = (a * 2) % 256; cy = (a >= 128); end
      7: begin res = a / 2; cy = (a % 2 == 1); end
`ifdef UC_MUL_EN
      8: begin full = a * b; res = full % 256; cy = (full >= 256); end
`endif
      default: ok = 1'b0;
    endcase
  endfunction

  // Updates the shadow outputs the way the sequencer should after its EXEC edge
  task automatic commitModel(input int a, input int b, input int op, output bit ok);
    int res;
    bit cy;
    refModel(a, b, op, ok, res, cy);
    if (ok) begin
      expTemp = W'(res); expCarry = cy; expZero = (res == 0); expError = 1'b0;
    end else begin
      expError = 1'b1;
    end
  endtask

  // One start pulse; checks every output on each cycle until back in IDLE
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                               input bit mutate);
    bit ok;
    int res;
    bit cy;
    int total;
    refModel(int'(a), int'(b), int'(op), ok, res, cy);
    total = ok ? 3 + H : 3;
    @(negedge clock);
    regA = a; regB = b; opcode = op; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int e = 0; e <= total; e++) begin
      if (e == 1 && mutate) begin
        regA = 8'h00; regB = 8'($urandom); opcode = 8'($urandom);
      end
      if (e == 2) commitModel(int'(a), int'(b), int'(op), ok);
      checkAll($sformatf("op%0h_e%0d", op, e), ok && e >= 2 && e < 2 + H, e == total - 1, e < total);
      if (e < total) @(negedge clock);
    end
  endtask

  initial begin
    bit ok;
    int total;
    logic [7:0] ra, rb, rop;

    #2;
    checkAll("reset", 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    resetN = 1'b1;

    applyStimulus(8'h0F, 8'h01, 8'd0, 1'b0);
    applyStimulus(8'hFF, 8'h01, 8'd0, 1'b0);
    applyStimulus(8'h00, 8'h01, 8'd1, 1'b0);
    applyStimulus(8'h81, 8'h00, 8'd7, 1'b1);
    applyStimulus(8'h0F, 8'h01, 8'd0, 1'b0);
    applyStimulus(8'h33, 8'h44, 8'h20, 1'b0);
    applyStimulus(8'hC3, 8'h0F, 8'd2, 1'b0);
    applyStimulus(8'h10, 8'h10, 8'd8, 1'b0);
    applyStimulus(8'h80, 8'h00, 8'd6, 1'b0);

    // Async reset while flagUC is high
    @(negedge clock);
    regA = 8'h12; regB = 8'h34; opcode = 8'd0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checkOutput("rst_pre.flagUC", 32'(flagUC), 32'd1);
    @(negedge clock);
    #2 resetN = 1'b0;
    #1;
    expTemp = '0; expCarry = 1'b0; expZero = 1'b0; expError = 1'b0;
    checkAll("rst_mid", 1'b0, 1'b0, 1'b0);

    // start held high across reset release: back-to-back ops with one IDLE cycle
    @(negedge clock);
    regA = 8'h05; regB = 8'h07; opcode = 8'd4; start = 1'b1; resetN = 1'b1;
    total = 3 + H;
    @(negedge clock);
    for (int e = 0; e <= total + 1; e++) begin
      if (e == 2) commitModel(5, 7, 4, ok);
      checkAll($sformatf("held_e%0d", e), e >= 2 && e < 2 + H, e == total - 1,
               (e < total) || (e == total + 1));
      if (e == total + 1) start = 1'b0;
      @(negedge clock);
    end
    for (int e = 0; e < total; e++) @(negedge clock);
    checkOutput("held_end.busy", 32'(busy), 32'd0);

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rop = ($urandom % 5 == 0) ? 8'($urandom) : 8'($urandom_range(0, 8));
      applyStimulus(ra, rb, rop, 1'($urandom % 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uc_sequencer.md
# uc_sequencer

Control-unit sequencer that reads operand register A, operand register B and the opcode register from the input register file, executes one ALU operation, and writes the result back into register A. Writeback uses the register file's `flagUC` override path: `tempRegA` carries the data and `flagUC` is the strobe. The result is also published on `bufferOut`, the read-only buffer slot that the register file shows on selector value 3. This block initiates register-A writeback; the register file responds to it.

## Interface
Parameters:
- `WIDTH`, 8, data width of operands, result and buffer.
- `WB_HOLD`, 1, cycles `flagUC` stays high per writeback; legal values are 1 or more.

Ports:
- `clock`  in  1  single system clock; all state changes on its rising edge.
- `resetN`  in  1  asynchronous, active-low reset.
- `start`  in  1  request one operation; level-sampled in IDLE only.
- `regA`  in  WIDTH  operand A (register-file `out0`).
- `regB`  in  WIDTH  operand B (register-file `out1`).
- `opcode`  in  8  operation code (register-file `out2`).
- `tempRegA`  out  WIDTH  writeback data for register A.
- `flagUC`  out  1  writeback strobe to the register file.
- `bufferOut`  out  WIDTH  last result (register-file `out3`).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of every operation.
- `error`  out  1  high when the last opcode was illegal.
- `carry`  out  1  carry/borrow/shift-out of the last legal operation.
- `zero`  out  1  last legal result equals 0.

## Operation
- Reset (async, `resetN`=0): state IDLE; all outputs 0, including `flagUC`, which deasserts immediately without waiting for a clock.
- FSM states: IDLE, FETCH, EXEC, WB, DONE.
  - IDLE to FETCH when `start`=1.
  - FETCH: latch `regA`, `regB` and `opcode` into internal registers, then go to EXEC.
  - EXEC: compute the WIDTH+1-bit result from the latched values into a register.
    - Opcode legal: go to WB.
    - Opcode illegal: go to DONE.
  - WB: hold for `WB_HOLD` cycles, then go to DONE.
  - DONE: one cycle, then go to IDLE.
- Opcodes (latched value); any other value is illegal:
  - 0 ADD: A+B.
  - 1 SUB: A−B; `carry` = borrow.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 NOT A.
  - 6 SHL A by 1; `carry` = old bit WIDTH−1.
  - 7 SHR A by 1; `carry` = old bit 0.
- Flag rules:
  - `carry` = 0 for opcodes 2–5.
  - `zero` = (result[WIDTH−1:0]==0).
  - Arithmetic wraps modulo 2^WIDTH; bit WIDTH of the result feeds only `carry`.
- On entry to WB, these update together on the same edge: `tempRegA`, `bufferOut`, `carry`, `zero`, and `error`←0.
  - They then hold until the next legal writeback or reset.
- Illegal opcode:
  - No WB and no `flagUC`.
  - `tempRegA`, `bufferOut`, `carry` and `zero` are unchanged.
  - `error`←1 on entry to DONE; it holds until the next operation's WB entry or reset.
- `start` outside IDLE is ignored and not queued.
- `start` held high continuously: a new operation begins on the edge after DONE→IDLE, so IDLE always lasts at least one cycle.
- Operand or opcode changes after the FETCH edge do not affect the running operation.
- `flagUC` drives an asynchronous set path in the register file. It must come directly from a flop, with no combinational logic after the register.

## Timing
- Edge 0 samples `start`=1. Edge 1 performs FETCH. Edge 2 ends EXEC.
- `flagUC`=1 and the new `tempRegA` are valid after edge 2.
  - `flagUC` stays high for exactly `WB_HOLD` cycles.
  - `tempRegA` is already stable on the cycle `flagUC` rises.
- `done`=1 for the single cycle after WB ends:
  - legal opcode: 3+`WB_HOLD` cycles after edge 0;
  - illegal opcode: 3 cycles after edge 0.
- `busy` rises after edge 0 and falls on the edge that leaves DONE.
- Reset asserted mid-operation: state, outputs and latched operands clear asynchronously. Operation resumes on the first clock edge after `resetN` rises.

## Configuration
- `UC_MUL_EN` defined: opcode 8 is legal and performs MUL.
  - Result = low WIDTH bits of A×B.
  - `carry` = 1 when the high WIDTH bits are nonzero.
  - Latency is identical to the other opcodes; the single-cycle multiply completes in EXEC.
- `UC_MUL_EN` undefined: opcode 8 is illegal and no multiplier is synthesized.

## Test plan
- A=0x0F, B=0x01, op=0, `start` pulse → `flagUC` high exactly cycles 3..3+`WB_HOLD`−1, `tempRegA`=`bufferOut`=0x10, `carry`=0, `zero`=0, `done` pulse at cycle 3+`WB_HOLD`.
- A=0xFF, B=0x01, op=0 → `tempRegA`=0x00, `carry`=1, `zero`=1; then A=0x00, B=0x01, op=1 → 0xFF, `carry`=1.
- A=0x81, op=7, `regA` changed to 0x00 one cycle after FETCH → result 0x40, `carry`=1, proving operands are latched.
- op=0x20 after a legal result 0x10 → no `flagUC`, `done` at cycle 3, `error`=1, `tempRegA` still 0x10; the next legal op clears `error`.
- `resetN` pulled low while `flagUC`=1 (`WB_HOLD`=4) → `flagUC` and all outputs 0 before the next edge; FSM in IDLE; `start` held high afterward begins a fresh operation.
- With `UC_MUL_EN`: A=0x10, B=0x10, op=8 → `tempRegA`=0x00, `carry`=1, `zero`=1. Without it, the same stimulus gives `error`=1 and no `flagUC`.
